// File: rtl/ivector_say_arbiter_pkg.sv
// Shared ivector definitions: default sizes, arbiter state encoding and id-width helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ivector_say_arbiter_pkg;

  localparam int IVEC_NREQ     = 4;
  localparam int IVEC_DW       = 192;
  localparam int IVEC_TAGDEPTH = 4;

  // Grant register is either empty or holding a requester id.
  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  // Bits needed to name one of n items; never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count from 0 up to depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ivector_tag_fifo.sv
// In-order tag queue remembering which requester issued each outstanding say.
// Latency: push visible at head one cycle later; pop frees a slot the next cycle.
// Backpressure: full/empty are registered; push while full and pop while empty are ignored.
module ivector_tag_fifo
  import ivector_say_arbiter_pkg::*;
#(
  parameter int DEPTH = IVEC_TAGDEPTH,
  parameter int WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [WIDTH-1:0]             head_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o
);

  localparam int PW = id_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards every queued tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ivector_say_arbiter.sv
// Round-robin arbiter muxing NREQ say ports onto one downstream say, routing heard replies back by tag.
// Latency: grant appears one cycle after want; say and heard paths are combinational once granted.
// Backpressure: say gated by say__RDY and registered tag-full; heard gated by the head requester's resp RDY.
module ivector_say_arbiter
  import ivector_say_arbiter_pkg::*;
#(
  parameter int NREQ     = IVEC_NREQ,
  parameter int DW       = IVEC_DW,
  parameter int TAGDEPTH = IVEC_TAGDEPTH
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic [NREQ-1:0]                 req_want,
  input  logic [NREQ-1:0]                 req_say__ENA,
  input  logic [NREQ*DW-1:0]              req_say_meth,
  input  logic [NREQ*DW-1:0]              req_say_v,
  output logic [NREQ-1:0]                 req_say__RDY,
  output logic                            say__ENA,
  output logic [DW-1:0]                   say_meth,
  output logic [DW-1:0]                   say_v,
  input  logic                            say__RDY,
  input  logic                            heard__ENA,
  input  logic [DW-1:0]                   heard_meth,
  input  logic [DW-1:0]                   heard_v,
  output logic                            heard__RDY,
  output logic [NREQ-1:0]                 resp_heard__ENA,
  output logic [DW-1:0]                   resp_heard_meth,
  output logic [DW-1:0]                   resp_heard_v,
  input  logic [NREQ-1:0]                 resp_heard__RDY,
  output logic [cnt_width(TAGDEPTH)-1:0]  outstanding
);

  localparam int IW = id_width(NREQ);
  localparam int CW = cnt_width(TAGDEPTH);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           grant_valid;
  logic           tag_full;
  logic           tag_empty;
  logic [IW-1:0]  head_tag;
  logic           heard_xfer;
  logic [CW-1:0]  tag_count;

  // First wanting requester after base, scanning base+1, base+2, ... and wrapping;
  // base itself is considered last, so it only wins when it is the sole wanter.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base,
                                            input logic [NREQ-1:0] want);
    logic [IW-1:0] res;
    int            idx;
    res = base;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(base) + k) % NREQ;
      if (want[IW'(idx)]) res = IW'(idx);
    end
    return res;
  endfunction

  assign grant_valid = (state_q == ARB_GRANTED);

  // Only the granted requester sees RDY; full is the registered flag, so a pop never frees a slot same-cycle.
  always_comb begin
    req_say__RDY = '0;
    if (grant_valid && say__RDY && !tag_full) req_say__RDY[grant_id_q] = 1'b1;
  end

  assign say__ENA = req_say__ENA[grant_id_q] & req_say__RDY[grant_id_q];
  assign say_meth = say__ENA ? req_say_meth[int'(grant_id_q)*DW +: DW] : '0;
  assign say_v    = say__ENA ? req_say_v[int'(grant_id_q)*DW +: DW]    : '0;

  // Grant FSM: rotate on every transfer, re-pick without moving the pointer when the holder stops wanting.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req_want) begin
          state_d    = ARB_GRANTED;
          grant_id_d = rr_pick(rr_ptr_q, req_want);
        end
      end
      ARB_GRANTED: begin
        if (say__ENA) begin
          rr_ptr_d = grant_id_q;
          if (|req_want) grant_id_d = rr_pick(grant_id_q, req_want);
          else           state_d    = ARB_IDLE;
        end else if (!req_want[grant_id_q]) begin
          if (|req_want) grant_id_d = rr_pick(rr_ptr_q, req_want);
          else           state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant registers; the pointer resets to the last id so requester 0 is favoured first.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= IW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Heard is accepted only when a tag is waiting and its owner can take the reply.
  assign heard__RDY      = !tag_empty && resp_heard__RDY[head_tag];
  assign heard_xfer      = heard__ENA && heard__RDY;
  assign resp_heard_meth = heard_meth;
  assign resp_heard_v    = heard_v;

  // Steer the heard strobe to the requester that issued the oldest outstanding say.
  always_comb begin
    resp_heard__ENA = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_heard__ENA[i] = heard_xfer && (head_tag == IW'(i));
    end
  end

  ivector_tag_fifo #(
    .DEPTH (TAGDEPTH),
    .WIDTH (IW)
  ) u_tag_fifo (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .push_i     (say__ENA),
    .push_dat_i (grant_id_q),
    .pop_i      (heard_xfer),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .head_o     (head_tag),
    .count_o    (tag_count)
  );

  assign outstanding = tag_count;

endmodule

// File: tb/tb_ivector_say_arbiter.sv
// Self-checking bench for ivector_say_arbiter: directed scenarios plus randomized traffic against a queue model.
// Latency: model predicts each cycle's combinational outputs from its state and the applied inputs.
// Backpressure: requester and heard enables are only driven where the model says RDY is high.
module tb_ivector_say_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 192;
  localparam int TAGDEPTH = 4;
  localparam int CW       = $clog2(TAGDEPTH + 1);

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [NREQ-1:0]      req_want;
  logic [NREQ-1:0]      req_say__ENA;
  logic [NREQ*DW-1:0]   req_say_meth;
  logic [NREQ*DW-1:0]   req_say_v;
  logic [NREQ-1:0]      req_say__RDY;
  logic                 say__ENA;
  logic [DW-1:0]        say_meth;
  logic [DW-1:0]        say_v;
  logic                 say__RDY;
  logic                 heard__ENA;
  logic [DW-1:0]        heard_meth;
  logic [DW-1:0]        heard_v;
  logic                 heard__RDY;
  logic [NREQ-1:0]      resp_heard__ENA;
  logic [DW-1:0]        resp_heard_meth;
  logic [DW-1:0]        resp_heard_v;
  logic [NREQ-1:0]      resp_heard__RDY;
  logic [CW-1:0]        outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: grant register, round-robin pointer and a queue of outstanding tags.
  bit m_gv;
  int m_gid;
  int m_rr;
  int m_q[$];

  logic [NREQ-1:0] cur_want;
  logic [NREQ-1:0] exp_rdy;
  logic [NREQ-1:0] exp_resp_ena;
  logic            exp_sena;
  logic            exp_hrdy;

  ivector_say_arbiter #(
    .NREQ     (NREQ),
    .DW       (DW),
    .TAGDEPTH (TAGDEPTH)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .req_want        (req_want),
    .req_say__ENA    (req_say__ENA),
    .req_say_meth    (req_say_meth),
    .req_say_v       (req_say_v),
    .req_say__RDY    (req_say__RDY),
    .say__ENA        (say__ENA),
    .say_meth        (say_meth),
    .say_v           (say_v),
    .say__RDY        (say__RDY),
    .heard__ENA      (heard__ENA),
    .heard_meth      (heard_meth),
    .heard_v         (heard_v),
    .heard__RDY      (heard__RDY),
    .resp_heard__ENA (resp_heard__ENA),
    .resp_heard_meth (resp_heard_meth),
    .resp_heard_v    (resp_heard_v),
    .resp_heard__RDY (resp_heard__RDY),
    .outstanding     (outstanding)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first wanter at base+1, base+2, ... modulo NREQ.
  function automatic int arb(input int base, input logic [NREQ-1:0] w);
    for (int off = 1; off <= NREQ; off++) begin
      if (w[(base + off) % NREQ]) return (base + off) % NREQ;
    end
    return base;
  endfunction

  task automatic model_reset();
    m_gv  = 1'b0;
    m_gid = 0;
    m_rr  = NREQ - 1;
    m_q.delete();
  endtask

  // ena_mode: 0 none, 1 every RDY, 2 random on RDY.
  // hmode: 0 none, 1 every RDY, 2 random on RDY, 3 random incl. illegal strobes while empty.
  task automatic apply(input logic [NREQ-1:0] want, input logic srdy, input int ena_mode,
                       input int hmode, input logic [NREQ-1:0] rrdy);
    logic [NREQ-1:0] ena;
    logic            he;
    logic [DW-1:0]   em;
    logic [DW-1:0]   ev;
    for (int w = 0; w < NREQ * DW / 32; w++) begin
      req_say_meth[w*32 +: 32] = $urandom();
      req_say_v[w*32 +: 32]    = $urandom();
    end
    for (int w = 0; w < DW / 32; w++) begin
      heard_meth[w*32 +: 32] = $urandom();
      heard_v[w*32 +: 32]    = $urandom();
    end
    cur_want        = want;
    req_want        = want;
    say__RDY        = srdy;
    resp_heard__RDY = rrdy;
    exp_rdy = (m_gv && srdy && m_q.size() < TAGDEPTH) ? (NREQ'(1) << m_gid) : '0;
    case (ena_mode)
      0:       ena = '0;
      1:       ena = exp_rdy;
      default: ena = exp_rdy & NREQ'($urandom_range(0, 15));
    endcase
    req_say__ENA = ena;
    exp_sena     = |(ena & exp_rdy);
    exp_hrdy     = 1'b0;
    if (m_q.size() > 0) exp_hrdy = rrdy[m_q[0]];
    case (hmode)
      0:       he = 1'b0;
      1:       he = exp_hrdy;
      2:       he = exp_hrdy && ($urandom_range(0, 1) == 1);
      default: he = (m_q.size() == 0 || exp_hrdy) && ($urandom_range(0, 1) == 1);
    endcase
    heard__ENA   = he;
    exp_resp_ena = '0;
    if (he && exp_hrdy) exp_resp_ena = NREQ'(1) << m_q[0];
    em = exp_sena ? req_say_meth[m_gid*DW +: DW] : '0;
    ev = exp_sena ? req_say_v[m_gid*DW +: DW]    : '0;
    #1;
    chk("req_say_rdy", DW'(req_say__RDY), DW'(exp_rdy));
    chk("say_ena", DW'(say__ENA), DW'(exp_sena));
    chk("say_meth", say_meth, em);
    chk("say_v", say_v, ev);
    chk("heard_rdy", DW'(heard__RDY), DW'(exp_hrdy));
    chk("resp_ena", DW'(resp_heard__ENA), DW'(exp_resp_ena));
    chk("resp_meth", resp_heard_meth, heard_meth);
    chk("resp_v", resp_heard_v, heard_v);
    chk("outstanding", DW'(outstanding), DW'(m_q.size()));
  endtask

  // Advance one clock and move the model by the same transfers.
  task automatic tick();
    int old_gid;
    @(posedge CLK);
    if (exp_resp_ena != '0) void'(m_q.pop_front());
    if (exp_sena) m_q.push_back(m_gid);
    old_gid = m_gid;
    if (!m_gv) begin
      if (cur_want != '0) begin
        m_gv  = 1'b1;
        m_gid = arb(m_rr, cur_want);
      end
    end else if (exp_sena) begin
      m_rr = old_gid;
      if (cur_want != '0) m_gid = arb(old_gid, cur_want);
      else                m_gv  = 1'b0;
    end else if (!cur_want[old_gid]) begin
      if (cur_want != '0) m_gid = arb(m_rr, cur_want);
      else                m_gv  = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic zero_inputs();
    req_want        = '0;
    req_say__ENA    = '0;
    req_say_meth    = '0;
    req_say_v       = '0;
    say__RDY        = 1'b0;
    heard__ENA      = 1'b0;
    heard_meth      = '0;
    heard_v         = '0;
    resp_heard__RDY = '0;
  endtask

  task automatic do_reset();
    nRST            = 1'b0;
    zero_inputs();
    req_want        = '1;
    say__RDY        = 1'b1;
    heard__ENA      = 1'b1;
    resp_heard__RDY = '1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_req_rdy", DW'(req_say__RDY), '0);
    chk("rst_say_ena", DW'(say__ENA), '0);
    chk("rst_heard_rdy", DW'(heard__RDY), '0);
    chk("rst_resp_ena", DW'(resp_heard__ENA), '0);
    chk("rst_outstanding", DW'(outstanding), '0);
    model_reset();
    zero_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int              order [5];
    logic [NREQ-1:0] route [3];
    order = '{0, 1, 2, 3, 0};
    route = '{4'b0010, 4'b1000, 4'b0010};
    zero_inputs();
    model_reset();

    // Sole wanter 2 after reset is granted one cycle later.
    do_reset();
    apply(4'b0100, 1'b1, 0, 0, 4'b1111);
    tick();
    apply(4'b0100, 1'b1, 0, 0, 4'b1111);
    chk("first_grant", DW'(req_say__RDY), DW'(4'b0100));
    tick();

    // All wanting, enable on every RDY: one transfer per cycle rotating 0,1,2,3,0.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      apply(4'b1111, 1'b1, 1, 1, 4'b1111);
      if (c >= 1) begin
        chk("fair_grant", DW'(req_say__RDY), DW'(NREQ'(1) << order[c-1]));
        chk("fair_xfer", DW'(say__ENA), DW'(1'b1));
        chk("fair_meth", say_meth, req_say_meth[order[c-1]*DW +: DW]);
      end
      tick();
    end

    // Fill the tag queue, then pop with no push in the same cycle.
    do_reset();
    repeat (6) begin
      apply(4'b1111, 1'b1, 1, 0, 4'b1111);
      tick();
    end
    apply(4'b1111, 1'b1, 1, 1, 4'b1111);
    chk("full_count", DW'(outstanding), DW'(4));
    chk("full_rdy", DW'(req_say__RDY), '0);
    chk("full_pop_rdy", DW'(heard__RDY), DW'(1'b1));
    tick();
    apply(4'b1111, 1'b1, 1, 0, 4'b1111);
    chk("after_pop_count", DW'(outstanding), DW'(3));
    chk("after_pop_rdy", DW'(req_say__RDY), DW'(4'b0001));
    tick();

    // Says from 1, 3, 1 route heard replies back in the same order.
    do_reset();
    apply(4'b0010, 1'b1, 0, 0, 4'b1111); tick();
    apply(4'b1000, 1'b1, 1, 0, 4'b1111); tick();
    apply(4'b0010, 1'b1, 1, 0, 4'b1111); tick();
    apply(4'b0000, 1'b1, 1, 0, 4'b1111); tick();
    for (int k = 0; k < 3; k++) begin
      apply(4'b0000, 1'b1, 0, 1, 4'b1111);
      chk("route_ena", DW'(resp_heard__ENA), DW'(route[k]));
      tick();
    end

    // Heard blocked by owner backpressure; grant held while downstream stalls.
    do_reset();
    apply(4'b0100, 1'b1, 0, 0, 4'b1111); tick();
    apply(4'b0100, 1'b1, 1, 0, 4'b1111); tick();
    repeat (3) begin
      apply(4'b0000, 1'b1, 0, 1, 4'b1011);
      chk("bp_heard_rdy", DW'(heard__RDY), '0);
      tick();
    end
    apply(4'b0000, 1'b1, 0, 1, 4'b1111);
    chk("bp_release", DW'(resp_heard__ENA), DW'(4'b0100));
    tick();
    apply(4'b1111, 1'b0, 1, 0, 4'b1111); tick();
    repeat (3) begin
      apply(4'b1111, 1'b0, 1, 0, 4'b1111);
      chk("stall_rdy", DW'(req_say__RDY), '0);
      tick();
    end
    apply(4'b1111, 1'b1, 0, 0, 4'b1111);
    chk("stall_hold", DW'(req_say__RDY), DW'(4'b1000));
    tick();

    // Asynchronous reset mid-cycle with three tags outstanding.
    do_reset();
    repeat (4) begin
      apply(4'b1111, 1'b1, 1, 0, 4'b1111);
      tick();
    end
    apply(4'b1111, 1'b1, 0, 1, 4'b1111);
    chk("pre_arst_count", DW'(outstanding), DW'(3));
    #2 nRST = 1'b0;
    #1;
    chk("arst_req_rdy", DW'(req_say__RDY), '0);
    chk("arst_say_ena", DW'(say__ENA), '0);
    chk("arst_heard_rdy", DW'(heard__RDY), '0);
    chk("arst_resp_ena", DW'(resp_heard__ENA), '0);
    chk("arst_count", DW'(outstanding), '0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post_arst_route", DW'(resp_heard__ENA), '0);
    zero_inputs();

    // Randomized traffic: sparse wants, then mostly-continuous wants.
    repeat (1500) begin
      apply(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 2, 3,
            NREQ'($urandom_range(0, 15)));
      tick();
    end
    repeat (1500) begin
      apply(~(NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15))),
            ($urandom_range(0, 7) != 0), 2, 3, NREQ'($urandom_range(0, 15)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ivector_say_arbiter.md
IVECTOR_SAY_ARBITER -- requirements
Module: ivector_say_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DW, default 192, width of meth and v; TAGDEPTH, default 4, maximum outstanding say transactions.
REQ-002 CLK  in  1  single clock; all state updates on posedge.
REQ-003 nRST  in  1  reset, asynchronous assert, active-low.
REQ-004 req_want  in  NREQ  per-requester level request intent; independent of req ENA.
REQ-005 req_say__ENA  in  NREQ  per-requester say enable; asserted only while that requester's RDY is high.
REQ-006 req_say_meth / req_say_v  in  NREQ*DW each  per-requester payloads; slice i = [i*DW +: DW].
REQ-007 req_say__RDY  out  NREQ  per-requester say ready.
REQ-008 say__ENA  out  1; say_meth / say_v  out  DW each; say__RDY  in  1  shared downstream say port.
REQ-009 heard__ENA  in  1; heard_meth / heard_v  in  DW each; heard__RDY  out  1  downstream indication port.
REQ-010 resp_heard__ENA  out  NREQ; resp_heard_meth / resp_heard_v  out  DW each, broadcast; resp_heard__RDY  in  NREQ.
REQ-011 outstanding  out  clog2(TAGDEPTH+1)  count of say transfers not yet answered by heard.

Function
REQ-012 A transfer on any ENA/RDY pair SHALL occur exactly when ENA is high in a cycle; RDY SHALL never depend combinationally on the same port's ENA.
REQ-013 Registered grant state: grant_valid (1b), grant_id (clog2 NREQ); arbiter pointer rr_ptr = last granted id.
REQ-014 FSM: IDLE (grant_valid=0) -> GRANTED when any req_want is set, grant_id = first set want scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ; visible the next cycle (1-cycle arbitration latency).
REQ-015 GRANTED -> hold while req_want[grant_id]=1 and no transfer; on transfer, rr_ptr <= grant_id and re-arbitrate that edge (the granted requester can lose to others; it regains the grant only if it is the sole wanter); if req_want[grant_id] drops without transfer, re-arbitrate the same way without updating rr_ptr.
REQ-016 Back-to-back: with continuous wants, one say transfer per cycle SHALL be sustainable, grant rotating every transfer.
REQ-017 req_say__RDY[i] = grant_valid & (grant_id==i) & say__RDY & !tag_full; all other bits 0.
REQ-018 say__ENA = req_say__ENA[grant_id] & req_say__RDY[grant_id]; say_meth/say_v = granted slice, zero when say__ENA=0.
REQ-019 Tag FIFO, depth TAGDEPTH, width clog2 NREQ: push grant_id on each say transfer; in-order pop on each heard transfer.
REQ-020 heard__RDY = !tag_empty & resp_heard__RDY[head_tag]; resp_heard__ENA[i] = heard__ENA & (head_tag==i); resp payload = heard payload, combinational.
REQ-021 Full with simultaneous pop: push stays blocked that cycle (RDY uses registered full only); empty: heard__RDY=0, and any heard__ENA is a protocol error, ignored.
REQ-022 outstanding: +1 on push, -1 on pop, unchanged on both; never exceeds TAGDEPTH; pointers wrap modulo TAGDEPTH.

Reset
REQ-023 On nRST low, asynchronously: grant_valid=0, grant_id=0, rr_ptr=NREQ-1 (so requester 0 wins first), tag FIFO empty, outstanding=0; hence all RDY and ENA outputs 0.
REQ-024 Reset mid-transaction SHALL discard all outstanding tags; heard arriving after reset is not routed.

Structure
REQ-025 NREQ, DW, TAGDEPTH defaults and the tag-id width function SHALL live in the shared ivector package.
REQ-026 The tag FIFO SHALL be one sub-module, ivector_tag_fifo (push/pop/full/empty/head), instantiated once.

Verification
REQ-027 Reset: after nRST release, only req_want[2]=1 -> grant to 2 one cycle later, req_say__RDY=4'b0100.
REQ-028 Fairness: wants=4'b1111, ENA every RDY cycle -> grant order 0,1,2,3,0, one transfer per cycle, say_meth equals each requester's slice.
REQ-029 Routing: say transfers from 1,3,1; heard x3 with all resp RDY -> resp_heard__ENA pulses 0010, 1000, 0010 in order.
REQ-030 Full: TAGDEPTH=4 transfers without heard -> outstanding=4, all req RDY=0; heard plus ENA in the same cycle -> pop only, outstanding=3, push next cycle.
REQ-031 Backpressure: head tag 2, resp_heard__RDY[2]=0 -> heard__RDY=0 until it rises; say__RDY=0 holds the grant with no rotation.
REQ-032 Async reset with outstanding=3 mid-cycle -> outputs 0 immediately, outstanding=0, heard__RDY=0.
